// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable Moore serial sequence detector with saturating match counter
module seq_detector_prog #(
  parameter int N = 4,
  parameter logic [N-1:0] PAT_DEFAULT = 4'b1010,
  parameter int LEN_DEFAULT = N,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);
  logic [N-1:0] pat_r, hist, new_hist, mask;
  logic [LEN_W-1:0] len_r, fill, new_fill, len_c;
  logic ovl_r, hit;
  // mask selects the low len_r bits so pattern and history compare over the active length only
  always_comb begin
    new_hist = {hist[N-2:0], x};
    new_fill = (fill == LEN_W'(N)) ? fill : fill + 1'b1;
    len_c = (cfg_len == '0) ? LEN_W'(1) : (cfg_len > LEN_W'(N)) ? LEN_W'(N) : cfg_len;
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = LEN_W'(i) < len_r;
    hit = en & (new_fill >= len_r) & (((new_hist ^ pat_r) & mask) == '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pat_r <= PAT_DEFAULT;
      len_r <= LEN_W'(LEN_DEFAULT);
      ovl_r <= 1'b1;
      hist <= '0;
      fill <= '0;
      z <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= cfg_pat;
      len_r <= len_c;
      ovl_r <= cfg_ovl;
      hist <= '0;
      fill <= '0;
      z <= 1'b0;
    end else begin
      z <= hit;
      if (en) begin
        hist <= new_hist;
        fill <= (hit & ~ovl_r) ? '0 : new_fill;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) match_cnt <= '0;
    else if (cnt_clr) match_cnt <= '0;
    else if (hit & ~cfg_load & (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: scoreboard bench against a bit-stream reference model, two counter widths
module tb_seq_detector_prog;
  logic clk = 0, reset = 0, x = 0, en = 0, cfg_load = 0, cfg_ovl = 0, cnt_clr = 0;
  logic [3:0] cfg_pat = 0;
  logic [2:0] cfg_len = 0;
  logic z, z2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int tests = 0, failed = 0;
  typedef struct {logic z; logic [7:0] c; logic [1:0] c2;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [3:0] mpat;
  int mlen, base, mcnt, mcnt2;
  logic movl;
  logic bits[$];

  seq_detector_prog dut (.clk(clk), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .z(z), .match_cnt(match_cnt));
  seq_detector_prog #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(match_cnt2));

  always #5 clk = ~clk;

  task automatic model_reset();
    mpat = 4'b1010; mlen = 4; movl = 1; bits.delete(); base = 0; mcnt = 0; mcnt2 = 0;
  endtask

  // drives one edge; the model remembers every consumed bit since the last flush
  task automatic drive(input logic xi, input logic ei, input logic ld = 0, input logic clr = 0);
    logic h;
    x = xi; en = ei; cfg_load = ld; cnt_clr = clr; h = 0;
    if (ld) begin
      mpat = cfg_pat; mlen = cfg_len == 0 ? 1 : cfg_len > 4 ? 4 : int'(cfg_len); movl = cfg_ovl;
      bits.delete(); base = 0;
    end else if (ei) begin
      bits.push_back(xi);
      if (bits.size() - base >= mlen) begin
        h = 1;
        for (int k = 0; k < mlen; k++) if (bits[bits.size() - mlen + k] !== mpat[mlen - 1 - k]) h = 0;
      end
      if (h) begin
        if (!movl) base = bits.size();
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    if (clr) begin mcnt = 0; mcnt2 = 0; end
    sb.push_back('{h, 8'(mcnt), 2'(mcnt2)});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 0; x = 1; en = 1;
    repeat (2) @(posedge clk);
    #1 tests++;
    if (z !== 0 || z2 !== 0 || match_cnt !== 0 || match_cnt2 !== 0) begin
      failed++; $display("FAIL reset: z=%b z2=%b cnt=%0d cnt2=%0d, expected all 0", z, z2, match_cnt, match_cnt2);
    end
    en = 0;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_default();
    logic [5:0] s = 6'b101010;
    for (int i = 5; i >= 0; i--) begin
      drive(s[i], 1);
      e = sb.pop_front(); tests++;
      if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
        failed++; $display("FAIL default[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
      end
    end
    tests++;
    if (match_cnt !== 8'd2) begin failed++; $display("FAIL default_count: match_cnt=%0d, expected 2", match_cnt); end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] s = 8'b10101010;
    for (int m = 0; m < 2; m++) begin
      cfg_pat = 4'b1010; cfg_len = 4; cfg_ovl = 1'(m);
      drive(0, 0, 1, 1);
      for (int i = 8; i >= 0; i--) begin
        if (i < 8) drive(s[i], 1);
        e = sb.pop_front(); tests++;
        if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
          failed++; $display("FAIL ovl%0d[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", m, i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
        end
      end
      tests++;
      if (match_cnt !== 8'(2 + m)) begin failed++; $display("FAIL ovl%0d_count: match_cnt=%0d, expected %0d", m, match_cnt, 2 + m); end
    end
  endtask

  task automatic test_en_gaps();
    logic [1:0] ops[7] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
    cfg_pat = 4'b1010; cfg_len = 4; cfg_ovl = 1;
    drive(0, 0, 1, 1);
    e = sb.pop_front();
    for (int i = 0; i < 7; i++) begin
      drive(ops[i][0], ops[i][1]);
      e = sb.pop_front(); tests++;
      if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
        failed++; $display("FAIL en_gaps[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
      end
    end
    tests++;
    if (match_cnt !== 8'd1) begin failed++; $display("FAIL en_gaps_count: match_cnt=%0d, expected 1", match_cnt); end
  endtask

  task automatic test_len_clamp();
    logic [3:0] pats[3] = '{4'b0110, 4'b0001, 4'b0010};
    logic [2:0] lens[3] = '{3'd3, 3'd0, 3'd7};
    logic [6:0] seqs[3] = '{7'b1110110, 7'b0000101, 7'b0010010};
    int ns[3] = '{7, 3, 6};
    int want[3] = '{2, 2, 1};
    for (int p = 0; p < 3; p++) begin
      cfg_pat = pats[p]; cfg_len = lens[p]; cfg_ovl = 1;
      drive(0, 0, 1, 1);
      for (int i = ns[p]; i >= 0; i--) begin
        if (i < ns[p]) drive(seqs[p][i], 1);
        e = sb.pop_front(); tests++;
        if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
          failed++; $display("FAIL len%0d[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", p, i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
        end
      end
      tests++;
      if (match_cnt !== 8'(want[p])) begin failed++; $display("FAIL len%0d_count: match_cnt=%0d, expected %0d", p, match_cnt, want[p]); end
    end
  endtask

  task automatic test_saturate();
    cfg_pat = 4'b0001; cfg_len = 1; cfg_ovl = 0;
    for (int i = 0; i <= 6; i++) begin
      if (i == 0) drive(0, 0, 1, 1);
      else if (i == 6) drive(1, 1, 0, 1);
      else drive(1, 1);
      e = sb.pop_front(); tests++;
      if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
        failed++; $display("FAIL sat[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
      end
      if (i == 5) begin
        tests++;
        if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin failed++; $display("FAIL sat_hold: cnt=%0d cnt2=%0d, expected 5 and 3", match_cnt, match_cnt2); end
      end
    end
    tests++;
    if (z !== 1'b1 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      failed++; $display("FAIL clr_vs_hit: z=%b cnt=%0d cnt2=%0d, expected z=1 cnt=0", z, match_cnt, match_cnt2);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pb[3] = '{8'b1010, 8'b101, 8'b01010};
    int pl[3] = '{4, 3, 5};
    for (int p = 0; p < 3; p++) begin
      #2 reset = 0;
      #1 tests++;
      if (z !== 0 || z2 !== 0 || match_cnt !== 0 || match_cnt2 !== 0) begin
        failed++; $display("FAIL async_rst%0d: z=%b z2=%b cnt=%0d cnt2=%0d, expected all 0", p, z, z2, match_cnt, match_cnt2);
      end
      #1 reset = 1;
      model_reset();
      for (int i = pl[p] - 1; i >= 0; i--) begin
        drive(pb[p][i], 1);
        e = sb.pop_front(); tests++;
        if (z !== e.z || z2 !== e.z || match_cnt !== e.c || match_cnt2 !== e.c2) begin
          failed++; $display("FAIL arst%0d[%0d]: z=%b z2=%b cnt=%0d cnt2=%0d, expected z=%b cnt=%0d cnt2=%0d", p, i, z, z2, match_cnt, match_cnt2, e.z, e.c, e.c2);
        end
      end
    end
    tests++;
    if (match_cnt !== 8'd1) begin failed++; $display("FAIL arst_count: match_cnt=%0d, expected 1", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_nonoverlap();
    test_en_gaps();
    test_len_clamp();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
